// File: rtl/elastic_circular_buffer.sv
// Elastic circular buffer: up to PAR_WRITE elements in and PAR_READ elements out per cycle.
// It tracks occupancy with an explicit count. Optional build macro: ECB_ERR_FLAGS_EN adds the sticky ovf_err/unf_err flags.
module elastic_circular_buffer #(
  parameter  int ROW_SIZE  = 8,
  parameter  int DEPTH     = 32,
  parameter  int PAR_WRITE = 4,
  parameter  int PAR_READ  = 4,
  localparam int PW        = $clog2(DEPTH),
  localparam int CW        = $clog2(DEPTH + 1),
  localparam int WNW       = $clog2(PAR_WRITE + 1),
  localparam int RNW       = $clog2(PAR_READ + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_valid,
  input  logic [WNW-1:0]               wr_num,
  input  logic [ROW_SIZE*PAR_WRITE-1:0] wr_data,
  output logic                         wr_ready,
  input  logic                         rd_en,
  input  logic [RNW-1:0]               rd_num,
  output logic                         rd_ready,
  output logic [ROW_SIZE*PAR_READ-1:0] rd_data,
  output logic [PAR_READ-1:0]          rd_lanes,
  output logic [CW-1:0]                count,
`ifdef ECB_ERR_FLAGS_EN
  output logic                         ovf_err,
  output logic                         unf_err,
`endif
  output logic                         full,
  output logic                         empty
);

  logic [ROW_SIZE-1:0] mem [DEPTH];
  logic [PW-1:0]       wptr;
  logic [PW-1:0]       rptr;
  logic [CW-1:0]       free_slots;
  logic [CW-1:0]       wr_add;
  logic [CW-1:0]       rd_sub;
  logic                wr_fire;
  logic                rd_fire;

  // The pointer is always below DEPTH, and n is never above DEPTH, so one conditional subtract is enough.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] ptr, input logic [PW:0] n);
    logic [PW:0] sum;
    sum = {1'b0, ptr} + n;
    if (sum >= (PW+1)'(DEPTH)) sum = sum - (PW+1)'(DEPTH);
    return sum[PW-1:0];
  endfunction

  // Readiness looks only at the registered count. This keeps the write side and the read side independent.
  assign free_slots = CW'(DEPTH) - count;
  assign wr_ready   = (wr_num <= WNW'(PAR_WRITE)) && (CW'(wr_num) <= free_slots);
  assign rd_ready   = (rd_num <= RNW'(PAR_READ)) && (CW'(rd_num) <= count);
  assign wr_fire    = wr_valid && wr_ready;
  assign rd_fire    = rd_en && rd_ready;
  assign wr_add     = wr_fire ? CW'(wr_num) : '0;
  assign rd_sub     = rd_fire ? CW'(rd_num) : '0;
  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);

  // NOTE: every output written here gets a default first, so that no path infers a latch.
  always_comb begin
    rd_data  = '0;
    rd_lanes = '0;
    for (int i = 0; i < PAR_READ; i++) begin
      rd_data[i*ROW_SIZE +: ROW_SIZE] = mem[wrap_add(rptr, (PW+1)'(i))];
      rd_lanes[i]                     = (CW'(i) < count);
    end
  end

  // NOTE: state is updated with non-blocking assignments only, so every read in this block sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      // NOTE: storage is cleared on reset, so stale rd_data lanes read as zero straight after reset.
      for (int j = 0; j < DEPTH; j++) mem[j] <= '0;
    end else begin
      if (wr_fire) begin
        for (int i = 0; i < PAR_WRITE; i++) begin
          if (WNW'(i) < wr_num)
            mem[wrap_add(wptr, (PW+1)'(i))] <= wr_data[i*ROW_SIZE +: ROW_SIZE];
        end
        wptr <= wrap_add(wptr, (PW+1)'(wr_num));
      end
      if (rd_fire) rptr <= wrap_add(rptr, (PW+1)'(rd_num));
      count <= count + wr_add - rd_sub;
    end
  end

`ifdef ECB_ERR_FLAGS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else begin
      if (wr_valid && !wr_ready && (wr_num != '0)) ovf_err <= 1'b1;
      if (rd_en && !rd_ready && (rd_num != '0))    unf_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_elastic_circular_buffer.sv
// Self-checking bench for elastic_circular_buffer (DEPTH=10, 4 in / 3 out), compared against an array/queue-level model.
module tb_elastic_circular_buffer;

  localparam int ROW   = 8;
  localparam int DEPTH = 10;
  localparam int PWR   = 4;
  localparam int PRD   = 3;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int WNW   = $clog2(PWR + 1);
  localparam int RNW   = $clog2(PRD + 1);
  localparam int VW    = CW + 4 + PRD + ROW * PRD;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 wr_valid;
  logic [WNW-1:0]       wr_num;
  logic [ROW*PWR-1:0]   wr_data;
  logic                 wr_ready;
  logic                 rd_en;
  logic [RNW-1:0]       rd_num;
  logic                 rd_ready;
  logic [ROW*PRD-1:0]   rd_data;
  logic [PRD-1:0]       rd_lanes;
  logic [CW-1:0]        count;
  logic                 full;
  logic                 empty;
`ifdef ECB_ERR_FLAGS_EN
  logic                 ovf_err;
  logic                 unf_err;
`endif

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: slot array plus integer pointers using plain modulo arithmetic.
  logic [ROW-1:0] m_mem [DEPTH];
  int             m_count, m_wptr, m_rptr;
  bit             m_ovf, m_unf;

  elastic_circular_buffer #(
    .ROW_SIZE (ROW),
    .DEPTH    (DEPTH),
    .PAR_WRITE(PWR),
    .PAR_READ (PRD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_valid(wr_valid),
    .wr_num  (wr_num),
    .wr_data (wr_data),
    .wr_ready(wr_ready),
    .rd_en   (rd_en),
    .rd_num  (rd_num),
    .rd_ready(rd_ready),
    .rd_data (rd_data),
    .rd_lanes(rd_lanes),
    .count   (count),
`ifdef ECB_ERR_FLAGS_EN
    .ovf_err (ovf_err),
    .unf_err (unf_err),
`endif
    .full    (full),
    .empty   (empty)
  );

  always #5 clk = ~clk;

  function automatic bit m_wr_ready(input int wn);
    return (wn <= PWR) && ((DEPTH - m_count) >= wn);
  endfunction

  function automatic bit m_rd_ready(input int rn);
    return (rn <= PRD) && (m_count >= rn);
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic [ROW*PRD-1:0] d;
    logic [PRD-1:0]     l;
    for (int i = 0; i < PRD; i++) begin
      d[i*ROW +: ROW] = m_mem[(m_rptr + i) % DEPTH];
      l[i]            = (i < m_count);
    end
    return {CW'(m_count), m_count == DEPTH, m_count == 0,
            m_wr_ready(int'(wr_num)), m_rd_ready(int'(rd_num)), l, d};
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {count, full, empty, wr_ready, rd_ready, rd_lanes, rd_data};
  endfunction

  function automatic logic [ROW*PWR-1:0] pack4(input int a, input int b, input int c, input int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  task automatic model_clear();
    m_count = 0;
    m_wptr  = 0;
    m_rptr  = 0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
  endtask

  // Called just after a falling edge; the extra #1 lets the combinational outputs settle.
  task automatic apply(input bit wv, input int wn, input logic [ROW*PWR-1:0] wd, input bit re, input int rn);
    wr_valid = wv;
    wr_num   = WNW'(wn);
    wr_data  = wd;
    rd_en    = re;
    rd_num   = RNW'(rn);
    #1;
  endtask

  task automatic idle();
    apply(1'b0, 0, '0, 1'b0, 0);
  endtask

  task automatic tick();
    int wn, rn;
    bit wf, rf;
    wn = int'(wr_num);
    rn = int'(rd_num);
    wf = wr_valid && m_wr_ready(wn);
    rf = rd_en && m_rd_ready(rn);
    if (wr_valid && !m_wr_ready(wn) && wn != 0) m_ovf = 1'b1;
    if (rd_en && !m_rd_ready(rn) && rn != 0)    m_unf = 1'b1;
    @(posedge clk);
    if (wf) begin
      for (int i = 0; i < wn; i++) m_mem[(m_wptr + i) % DEPTH] = wr_data[i*ROW +: ROW];
      m_wptr = (m_wptr + wn) % DEPTH;
    end
    if (rf) m_rptr = (m_rptr + rn) % DEPTH;
    m_count = m_count + (wf ? wn : 0) - (rf ? rn : 0);
    @(negedge clk);
  endtask

  task automatic hard_reset();
    wr_valid = 1'b0;
    rd_en    = 1'b0;
    rst      = 1'b0;
    model_clear();
    #1;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_clear();
    idle();
    @(negedge clk);
    apply(1'b0, 4, '0, 1'b0, 0);
    vectors++; if (count !== '0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", count); end
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty: got %b expected 1", empty); end
    vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %b expected 0", full); end
    vectors++; if (rd_lanes !== '0) begin miscompares++; $display("FAIL reset_lanes: got %b expected 000", rd_lanes); end
    vectors++; if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL reset_wr_ready: got %b expected 1", wr_ready); end
    vectors++; if (rd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_rd_ready0: got %b expected 1", rd_ready); end
    vectors++; if (rd_data !== '0) begin miscompares++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
    apply(1'b0, 4, '0, 1'b0, 1);
    vectors++; if (rd_ready !== 1'b0) begin miscompares++; $display("FAIL reset_rd_ready1: got %b expected 0", rd_ready); end
`ifdef ECB_ERR_FLAGS_EN
    vectors++; if ({ovf_err, unf_err} !== 2'b00) begin miscompares++; $display("FAIL reset_err: got %b expected 00", {ovf_err, unf_err}); end
`endif
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fill_wrap();
    hard_reset();
    apply(1'b1, 3, pack4(1, 2, 3, 0), 1'b0, 0);
    vectors++; if (obs_vec() !== exp_vec()) begin miscompares++; $display("FAIL fill_w3: got %h expected %h", obs_vec(), exp_vec()); end
    tick();
    apply(1'b1, 4, pack4(4, 5, 6, 7), 1'b0, 0);
    tick();
    apply(1'b1, 3, pack4(8, 9, 10, 99), 1'b0, 0);
    tick();
    apply(1'b1, 1, pack4(77, 0, 0, 0), 1'b0, 0);
    vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL fill_full: got %b expected 1", full); end
    vectors++; if (count !== CW'(10)) begin miscompares++; $display("FAIL fill_count: got %0d expected 10", count); end
    vectors++; if (wr_ready !== 1'b0) begin miscompares++; $display("FAIL fill_wr_ready: got %b expected 0", wr_ready); end
    tick();
    apply(1'b0, 0, '0, 1'b1, 3);
    vectors++; if (rd_data !== 24'h030201) begin miscompares++; $display("FAIL fill_rd3: got %h expected 030201", rd_data); end
    vectors++; if (rd_ready !== 1'b1) begin miscompares++; $display("FAIL fill_rd_ready: got %b expected 1", rd_ready); end
    tick();
    idle();
    vectors++; if (count !== CW'(7)) begin miscompares++; $display("FAIL fill_count7: got %0d expected 7", count); end
    apply(1'b1, 3, pack4(11, 12, 13, 0), 1'b0, 0);
    tick();
    idle();
    vectors++; if (obs_vec() !== exp_vec()) begin miscompares++; $display("FAIL wrap_state: got %h expected %h", obs_vec(), exp_vec()); end
    apply(1'b0, 0, '0, 1'b1, 3);
    vectors++; if (rd_data !== 24'h060504) begin miscompares++; $display("FAIL wrap_rd_a: got %h expected 060504", rd_data); end
    tick();
    apply(1'b0, 0, '0, 1'b1, 3);
    vectors++; if (rd_data !== 24'h090807) begin miscompares++; $display("FAIL wrap_rd_b: got %h expected 090807", rd_data); end
    tick();
    apply(1'b0, 0, '0, 1'b1, 3);
    vectors++; if (rd_data !== 24'h0C0B0A) begin miscompares++; $display("FAIL wrap_rd_c: got %h expected 0c0b0a", rd_data); end
    tick();
    apply(1'b0, 0, '0, 1'b1, 1);
    vectors++; if (rd_data[7:0] !== 8'h0D) begin miscompares++; $display("FAIL wrap_rd_d: got %h expected 0d", rd_data[7:0]); end
    vectors++; if (rd_lanes !== 3'b001) begin miscompares++; $display("FAIL wrap_lanes: got %b expected 001", rd_lanes); end
    tick();
    idle();
    vectors++; if (empty !== 1'b1 || count !== '0) begin miscompares++; $display("FAIL wrap_drained: got empty=%b count=%0d expected 1/0", empty, count); end
  endtask

  task automatic test_simultaneous();
    hard_reset();
    apply(1'b1, 4, pack4(21, 22, 23, 24), 1'b0, 0);
    tick();
    apply(1'b1, 1, pack4(25, 0, 0, 0), 1'b0, 0);
    tick();
    apply(1'b1, 4, pack4(26, 27, 28, 29), 1'b1, 3);
    vectors++; if ({wr_ready, rd_ready} !== 2'b11) begin miscompares++; $display("FAIL simul_ready: got %b expected 11", {wr_ready, rd_ready}); end
    vectors++; if (rd_data !== 24'h171615) begin miscompares++; $display("FAIL simul_rd: got %h expected 171615", rd_data); end
    tick();
    idle();
    vectors++; if (count !== CW'(6)) begin miscompares++; $display("FAIL simul_count6: got %0d expected 6", count); end
    apply(1'b1, 4, pack4(30, 31, 32, 33), 1'b0, 0);
    tick();
    apply(1'b1, 1, pack4(34, 0, 0, 0), 1'b1, 1);
    vectors++; if ({wr_ready, rd_ready} !== 2'b01) begin miscompares++; $display("FAIL simul_full_ready: got %b expected 01", {wr_ready, rd_ready}); end
    tick();
    idle();
    vectors++; if (count !== CW'(DEPTH - 1)) begin miscompares++; $display("FAIL simul_count9: got %0d expected 9", count); end
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, 0, '0, 1'b1, 3);
      vectors++; if (obs_vec() !== exp_vec()) begin miscompares++; $display("FAIL simul_drain%0d: got %h expected %h", k, obs_vec(), exp_vec()); end
      tick();
    end
    apply(1'b1, 1, pack4(50, 0, 0, 0), 1'b1, 1);
    vectors++; if ({wr_ready, rd_ready} !== 2'b10) begin miscompares++; $display("FAIL simul_empty_ready: got %b expected 10", {wr_ready, rd_ready}); end
    tick();
    idle();
    vectors++; if (count !== CW'(1) || rd_data[7:0] !== 8'd50) begin miscompares++; $display("FAIL simul_empty_wr: got count=%0d lane0=%0d expected 1/50", count, rd_data[7:0]); end
  endtask

  task automatic test_blocked();
    hard_reset();
    apply(1'b1, 2, pack4(31, 32, 0, 0), 1'b0, 0);
    tick();
    apply(1'b0, 0, '0, 1'b1, 3);
    vectors++; if (rd_ready !== 1'b0) begin miscompares++; $display("FAIL blk_rd_ready: got %b expected 0", rd_ready); end
    tick();
    idle();
    vectors++; if (count !== CW'(2) || rd_data[7:0] !== 8'd31) begin miscompares++; $display("FAIL blk_rd_state: got count=%0d lane0=%0d expected 2/31", count, rd_data[7:0]); end
    apply(1'b1, 5, pack4(1, 2, 3, 4), 1'b0, 0);
    vectors++; if (wr_ready !== 1'b0) begin miscompares++; $display("FAIL blk_wr_ready: got %b expected 0", wr_ready); end
    tick();
    idle();
    vectors++; if (count !== CW'(2)) begin miscompares++; $display("FAIL blk_wr_count: got %0d expected 2", count); end
`ifdef ECB_ERR_FLAGS_EN
    vectors++; if ({ovf_err, unf_err} !== 2'b11) begin miscompares++; $display("FAIL blk_err_set: got %b expected 11", {ovf_err, unf_err}); end
    tick();
    tick();
    vectors++; if ({ovf_err, unf_err} !== 2'b11) begin miscompares++; $display("FAIL blk_err_sticky: got %b expected 11", {ovf_err, unf_err}); end
`endif
    apply(1'b1, 0, pack4(9, 9, 9, 9), 1'b1, 0);
    vectors++; if ({wr_ready, rd_ready} !== 2'b11) begin miscompares++; $display("FAIL blk_zero_ready: got %b expected 11", {wr_ready, rd_ready}); end
    tick();
    idle();
    vectors++; if (obs_vec() !== exp_vec()) begin miscompares++; $display("FAIL blk_zero_state: got %h expected %h", obs_vec(), exp_vec()); end
  endtask

  task automatic test_reset_mid();
    hard_reset();
    apply(1'b1, 4, pack4(1, 2, 3, 4), 1'b0, 0);
    tick();
    apply(1'b1, 3, pack4(5, 6, 7, 0), 1'b0, 0);
    tick();
    apply(1'b1, 2, pack4(8, 9, 0, 0), 1'b1, 1);
    #2;
    rst      = 1'b0;
    wr_valid = 1'b0;
    rd_en    = 1'b0;
    model_clear();
    #1;
    vectors++; if (count !== '0 || empty !== 1'b1 || rd_lanes !== '0) begin miscompares++; $display("FAIL rstmid_async: got count=%0d empty=%b lanes=%b expected 0/1/000", count, empty, rd_lanes); end
    @(negedge clk);
    #2;
    rst = 1'b1;
    @(negedge clk);
    apply(1'b1, 3, pack4(41, 42, 43, 0), 1'b0, 0);
    tick();
    apply(1'b0, 0, '0, 1'b1, 1);
    vectors++; if (rd_data[7:0] !== 8'd41) begin miscompares++; $display("FAIL rstmid_first: got %0d expected 41", rd_data[7:0]); end
    vectors++; if (obs_vec() !== exp_vec()) begin miscompares++; $display("FAIL rstmid_state: got %h expected %h", obs_vec(), exp_vec()); end
    tick();
  endtask

  task automatic test_random();
    int wn, rn;
    bit wv, re;
    hard_reset();
    for (int n = 0; n < 1500; n++) begin
      wv = ($urandom_range(0, 3) != 0);
      re = ($urandom_range(0, 3) != 0);
      wn = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
      rn = $urandom_range(0, 3);
      apply(wv, wn, ROW*PWR'($urandom), re, rn);
      vectors++; if (obs_vec() !== exp_vec()) begin miscompares++; $display("FAIL rand_%0d: got %h expected %h", n, obs_vec(), exp_vec()); end
`ifdef ECB_ERR_FLAGS_EN
      vectors++; if ({ovf_err, unf_err} !== {m_ovf, m_unf}) begin miscompares++; $display("FAIL rand_err_%0d: got %b expected %b", n, {ovf_err, unf_err}, {m_ovf, m_unf}); end
`endif
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_fill_wrap();
    test_simultaneous();
    test_blocked();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
